ptc_lock_tracker: RTL and testbench

//  Downstream of the PTC SAR loop. Times the SAR binary search and latches its final
//  10-bit code, then closes the loop in tracking mode: filtered up/down stepping of the

---
 rtl/ptc_lock_tracker.sv | 157 +++++++++++++++
 tb/tb_ptc_lock_tracker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ptc_lock_tracker.sv
// ptc_lock_tracker
//   Times the SAR binary search, latches its final code, then tracks the
//   delay-line code with filtered up/down steps from the PD comparator.
//   Flags lock on a run of alternating steps and flags code saturation.
//   Optional feature macro: PTC_TRACK_HOLD_EN adds a 'hold' input that freezes
//   tracking while asserted in TRACK/LOCKED.
//
// Handshake note: this block has no valid/ready interfaces. 'start' is a
// single-cycle command pulse sampled on clk4. It is accepted in any state and
// always wins over tracking activity in the same cycle.
module ptc_lock_tracker #(
  parameter int CODE_W   = 10,
  parameter int FILT_TH  = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic              clk4,
  input  logic              rst_n,
  input  logic              start,
  input  logic              COMP,
  input  logic [CODE_W-1:0] sar_q,
`ifdef PTC_TRACK_HOLD_EN
  input  logic              hold,
`endif
  output logic [CODE_W-1:0] code,
  output logic [1:0]        state,
  output logic              lock,
  output logic              at_max,
  output logic              at_min
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int ACC_W = 5;
  localparam int ACQ_W = $clog2(CODE_W);

  localparam logic [CODE_W-1:0]       CODE_MAX = '1;
  localparam logic [CODE_W-1:0]       CODE_RST = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] TH_POS   = ACC_W'(FILT_TH);
  localparam logic signed [ACC_W-1:0] TH_NEG   = ACC_W'(-FILT_TH);
  localparam logic [3:0]              LOCK_MAX = 4'(LOCK_CNT);
  localparam logic [ACQ_W-1:0]        ACQ_LAST = ACQ_W'(CODE_W - 1);

  state_t                   state_q, state_d;
  logic [CODE_W-1:0]        code_q, code_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [ACQ_W-1:0]         acq_cnt_q, acq_cnt_d;
  logic [3:0]               alt_cnt_q, alt_cnt_d;
  logic                     last_dir_q, last_dir_d;  // 1 = last step was up
  logic                     first_q, first_d;        // next step is the first after ACQ
  logic                     track_en;
  logic                     step_up;

  // Tracking gate: hold freezes the loop only when the feature is built in.
`ifdef PTC_TRACK_HOLD_EN
  always_comb track_en = ~hold;
`else
  always_comb track_en = 1'b1;
`endif

  // State and datapath registers, all asynchronously cleared.
  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      code_q     <= CODE_RST;
      acc_q      <= '0;
      acq_cnt_q  <= '0;
      alt_cnt_q  <= '0;
      last_dir_q <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      acc_q      <= acc_d;
      acq_cnt_q  <= acq_cnt_d;
      alt_cnt_q  <= alt_cnt_d;
      last_dir_q <= last_dir_d;
      first_q    <= first_d;
    end
  end

  // Next-state logic: start abort, acquisition timing, vote filter, lock detect.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    acc_d      = acc_q;
    acq_cnt_d  = acq_cnt_q;
    alt_cnt_d  = alt_cnt_q;
    last_dir_d = last_dir_q;
    first_d    = first_q;
    step_up    = 1'b0;
    acc_sum    = COMP ? (acc_q + ACC_ONE) : (acc_q - ACC_ONE);

    if (start) begin
      state_d   = ST_ACQ;
      acq_cnt_d = '0;
      acc_d     = '0;
      alt_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ACQ: begin
          acq_cnt_d = acq_cnt_q + 1'b1;
          if (acq_cnt_q == ACQ_LAST) begin
            code_d    = sar_q;
            state_d   = ST_TRACK;
            first_d   = 1'b1;
            acq_cnt_d = '0;
          end
        end
        ST_TRACK, ST_LOCKED: begin
          if (track_en) begin
            if ((acc_sum == TH_POS) || (acc_sum == TH_NEG)) begin
              acc_d   = '0;
              step_up = (acc_sum == TH_POS);
              // Saturated steps leave the code alone but still count.
              if (step_up) begin
                if (code_q != CODE_MAX) code_d = code_q + 1'b1;
              end else begin
                if (code_q != '0) code_d = code_q - 1'b1;
              end
              if (first_q) begin
                alt_cnt_d = '0;
                first_d   = 1'b0;
              end else if (step_up != last_dir_q) begin
                alt_cnt_d = (alt_cnt_q == LOCK_MAX) ? LOCK_MAX : alt_cnt_q + 1'b1;
              end else begin
                alt_cnt_d = '0;
                state_d   = ST_TRACK;
              end
              last_dir_d = step_up;
              if (alt_cnt_d == LOCK_MAX) state_d = ST_LOCKED;
            end else begin
              acc_d = acc_sum;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: live SAR pass-through during acquisition, flags in tracking states.
  always_comb begin
    code   = (state_q == ST_ACQ) ? sar_q : code_q;
    state  = state_q;
    lock   = (state_q == ST_LOCKED);
    at_max = ((state_q == ST_TRACK) || (state_q == ST_LOCKED)) && (code_q == CODE_MAX);
    at_min = ((state_q == ST_TRACK) || (state_q == ST_LOCKED)) && (code_q == '0);
  end

endmodule

// File: tb/tb_ptc_lock_tracker.sv
// Testbench for ptc_lock_tracker: directed scenarios followed by randomized
// stimulus, all outputs compared each cycle against a behavioural model.
module tb_ptc_lock_tracker;

  localparam int CODE_W   = 10;
  localparam int FILT_TH  = 4;
  localparam int LOCK_CNT = 8;
  localparam int CMAX     = (1 << CODE_W) - 1;

  // ---------------- clock / reset ----------------
  logic              clk4 = 1'b0;
  logic              rst_n;
  logic              start;
  logic              COMP;
  logic [CODE_W-1:0] sar_q;
`ifdef PTC_TRACK_HOLD_EN
  logic              hold;
`endif
  logic [CODE_W-1:0] code;
  logic [1:0]        state;
  logic              lock;
  logic              at_max;
  logic              at_min;

  always #5 clk4 = ~clk4;

  ptc_lock_tracker #(.CODE_W(CODE_W), .FILT_TH(FILT_TH), .LOCK_CNT(LOCK_CNT)) dut (
    .clk4   (clk4),
    .rst_n  (rst_n),
    .start  (start),
    .COMP   (COMP),
    .sar_q  (sar_q),
`ifdef PTC_TRACK_HOLD_EN
    .hold   (hold),
`endif
    .code   (code),
    .state  (state),
    .lock   (lock),
    .at_max (at_max),
    .at_min (at_min)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 acquiring, 2 tracking, 3 locked
  int m_mode, m_code, m_votes, m_acq_cycles, m_alt, m_last_move;
  bit m_fresh;

  task automatic model_reset();
    m_mode = 0; m_code = 1 << (CODE_W - 1); m_votes = 0;
    m_acq_cycles = 0; m_alt = 0; m_last_move = -1; m_fresh = 0;
  endtask

  task automatic model_step(input bit s, input bit c, input int sar, input bit h);
    int move;
    if (s) begin
      m_mode = 1; m_acq_cycles = 0; m_votes = 0; m_alt = 0;
      return;
    end
    if (m_mode == 1) begin
      m_acq_cycles++;
      if (m_acq_cycles == CODE_W) begin
        m_code = sar; m_mode = 2; m_fresh = 1;
      end
    end else if (m_mode >= 2 && !h) begin
      m_votes += c ? 1 : -1;
      if (m_votes == FILT_TH || m_votes == -FILT_TH) begin
        move = (m_votes > 0) ? 1 : -1;
        m_votes = 0;
        m_code = m_code + move;
        if (m_code > CMAX) m_code = CMAX;
        if (m_code < 0) m_code = 0;
        if (m_fresh) begin
          m_alt = 0; m_fresh = 0;
        end else if (move != m_last_move) begin
          if (m_alt < LOCK_CNT) m_alt++;
        end else begin
          m_alt = 0; m_mode = 2;
        end
        m_last_move = move;
        if (m_alt == LOCK_CNT) m_mode = 3;
      end
    end
  endtask

  task automatic check_all(input int sar);
    exp_q.push_back(32'((m_mode == 1) ? sar : m_code));
    exp_q.push_back(32'(m_mode));
    exp_q.push_back(32'(m_mode == 3));
    exp_q.push_back(32'(m_mode >= 2 && m_code == CMAX));
    exp_q.push_back(32'(m_mode >= 2 && m_code == 0));
    check("code",   32'(code),   exp_q.pop_front());
    check("state",  32'(state),  exp_q.pop_front());
    check("lock",   32'(lock),   exp_q.pop_front());
    check("at_max", 32'(at_max), exp_q.pop_front());
    check("at_min", 32'(at_min), exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  // Drives one cycle of inputs just after a falling edge, checks, then advances.
  task automatic tick(input bit s, input bit c, input int sar, input bit h);
    bit h_eff;
    start = s; COMP = c; sar_q = CODE_W'(sar);
`ifdef PTC_TRACK_HOLD_EN
    hold = h; h_eff = h;
`else
    h_eff = 1'b0 & h;
`endif
    #1;
    check_all(sar);
    model_step(s, c, sar, h_eff);
    @(posedge clk4);
    @(negedge clk4);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_state", 32'(state), 32'd0);
    check("rst_code",  32'(code),  32'(1 << (CODE_W - 1)));
    check("rst_lock",  32'(lock),  32'd0);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len, kind, sar;
    bit c0, c;
    start = 1'b0; COMP = 1'b0; sar_q = '0;
`ifdef PTC_TRACK_HOLD_EN
    hold = 1'b0;
`endif
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk4);
    pulse_reset();
    check("rst_at_max", 32'(at_max), 32'd0);
    check("rst_at_min", 32'(at_min), 32'd0);

    // Acquisition of 700, latched 10 cycles after the start edge.
    tick(1, 0, 700, 0);
    repeat (CODE_W) tick(0, 0, 700, 0);
    check("acq_state", 32'(state), 32'd2);
    check("acq_code",  32'(code),  32'd700);

    // Eight up votes: two steps.
    repeat (8) tick(0, 1, 700, 0);
    check("up2_code", 32'(code), 32'd702);

    // Alternating 4/4 blocks: eight alternating steps reach lock.
    for (int b = 0; b < 8; b++)
      repeat (FILT_TH) tick(0, b[0], 700, 0);
    check("lock_set",  32'(lock), 32'd1);
    check("lock_code", 32'(code), 32'd702);
    repeat (FILT_TH) tick(0, 1, 700, 0);
    check("lock_lost",  32'(lock),  32'd0);
    check("lost_state", 32'(state), 32'd2);
    check("lost_code",  32'(code),  32'd703);

    // Start while locked re-acquires a new code.
    for (int b = 0; b < 9; b++)
      repeat (FILT_TH) tick(0, ~b[0], 300, 0);
    tick(1, 0, 300, 0);
    check("restart_lock",  32'(lock),  32'd0);
    check("restart_state", 32'(state), 32'd1);
    repeat (CODE_W) tick(0, 1, 300, 0);
    check("restart_code", 32'(code), 32'd300);

    // Upper saturation.
    tick(1, 0, CMAX - 2, 0);
    repeat (CODE_W) tick(0, 0, CMAX - 2, 0);
    repeat (FILT_TH * 5) tick(0, 1, 0, 0);
    check("sat_max_code", 32'(code),   32'(CMAX));
    check("sat_max_flag", 32'(at_max), 32'd1);

    // Lower saturation.
    tick(1, 0, 2, 0);
    repeat (CODE_W) tick(0, 0, 2, 0);
    repeat (FILT_TH * 5) tick(0, 0, 0, 0);
    check("sat_min_code", 32'(code),   32'd0);
    check("sat_min_flag", 32'(at_min), 32'd1);

`ifdef PTC_TRACK_HOLD_EN
    repeat (20) tick(0, 1'($urandom_range(0, 1)), 0, 1);
    check("hold_code", 32'(code), 32'd0);
`endif

    // Reset in the middle of acquisition.
    tick(1, 0, 555, 0);
    repeat (4) tick(0, 0, 555, 0);
    pulse_reset();

    // Randomized segments.
    for (int seg = 0; seg < 80; seg++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(8, 60);
      c0   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        sar = ($urandom_range(0, 1) == 1) ? $urandom_range(CMAX - 3, CMAX) : $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 1) sar = $urandom_range(0, CMAX);
        tick(1, 0, sar, 0);
        repeat (CODE_W) tick(0, 0, sar, 0);
      end
      for (int i = 0; i < len; i++) begin
        case (kind)
          0:       c = 1'($urandom_range(0, 1));
          1:       c = ((i / FILT_TH) % 2 == 1) ? ~c0 : c0;
          2:       c = c0;
          default: c = ($urandom_range(0, 7) == 0) ? 1'($urandom_range(0, 1))
                                                   : (((i / FILT_TH) % 2 == 1) ? ~c0 : c0);
        endcase
        tick(($urandom_range(0, 199) == 0), c, $urandom_range(0, CMAX),
             ($urandom_range(0, 9) == 0));
      end
      if ($urandom_range(0, 19) == 0) pulse_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
